// File: rtl/note_store_player.sv
// Note store and square-wave tone player: records switch notes into a 16-entry
// register file and plays the entry selected by the controller's note index.
module note_store_player #(
  parameter int TONE_SHIFT = 0,
  parameter int CNT_W      = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_note,
  input  logic       ld_play,
  input  logic [3:0] note_counter,
  input  logic [2:0] note_in,
  input  logic       clear,
  output logic       tone_out,
  output logic [2:0] cur_note,
  output logic [4:0] notes_stored,
  output logic       full
);

  typedef enum logic {IDLE, TONE} state_t;

  // Half-period in clocks; a shift that empties the entry still toggles every cycle.
  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] n);
    logic [16:0] base;
    case (n)
      3'd1:    base = 17'd95556;
      3'd2:    base = 17'd85131;
      3'd3:    base = 17'd75843;
      3'd4:    base = 17'd71586;
      3'd5:    base = 17'd63776;
      3'd6:    base = 17'd56818;
      3'd7:    base = 17'd50619;
      default: base = 17'd1;
    endcase
    base = base >> TONE_SHIFT;
    if (base == 17'd0) base = 17'd1;
    return CNT_W'(base);
  endfunction

  logic             ld_note_q;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       mem_q [16];
  logic [2:0]       cur_note_q, cur_note_d;
  logic [2:0]       prev_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             tone_q, tone_d;

  logic             we, fwd, rd_valid;
  logic [3:0]       wr_ptr;
  logic [2:0]       rd_data;
  logic [CNT_W-1:0] half_cur;

  assign wr_ptr = cnt_q[3:0];
  assign full   = cnt_q[4];
  // clear wins over a simultaneous record edge; a full store drops writes.
  assign we     = ld_note & ~ld_note_q & ~clear & ~full;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)   cnt_d = 5'd0;
    else if (we) cnt_d = cnt_q + 5'd1;
  end

  // Write-first: a read of the slot being written returns the incoming note.
  assign fwd      = we & (note_counter == wr_ptr);
  assign rd_valid = ld_play & ((5'(note_counter) < cnt_q) | fwd);
  assign rd_data  = fwd ? note_in : mem_q[note_counter];
  assign cur_note_d = rd_valid ? rd_data : 3'd0;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr] <= note_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_note_q  <= 1'b0;
      cnt_q      <= 5'd0;
      cur_note_q <= 3'd0;
      prev_q     <= 3'd0;
    end else begin
      ld_note_q  <= ld_note;
      cnt_q      <= cnt_d;
      cur_note_q <= cur_note_d;
      prev_q     <= cur_note_q;
    end
  end

  assign half_cur = half_of(cur_note_q);

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    tone_d  = tone_q;
    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        tone_d = 1'b0;
        if (cur_note_q != 3'd0) state_d = TONE;
      end
      TONE: begin
        if (cur_note_q == 3'd0) begin
          state_d = IDLE;
          tcnt_d  = '0;
          tone_d  = 1'b0;
        end else if (cur_note_q != prev_q) begin
          // New note restarts from phase 0.
          tcnt_d = '0;
          tone_d = 1'b0;
        end else if (tcnt_q == half_cur - CNT_W'(1)) begin
          tcnt_d = '0;
          tone_d = ~tone_q;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      tone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      tone_q  <= tone_d;
    end
  end

  assign tone_out     = tone_q;
  assign cur_note     = cur_note_q;
  assign notes_stored = cnt_q;

endmodule
